mmio_responder: RTL and testbench

Memory-mapped I/O responder on the processor's data-memory bus. It decodes the same address/data/write-enable signals the processor drives toward dmem and answers a small register window: a cycle counter, a byte-wide transmit FIFO drained by an external consumer, a status word and a scratch register. It returns registered read data plus a registered select flag, so the top level can mux its output against dmem's `q` with matching one-cycle latency.

---
 rtl/mmio_responder.sv | 179 +++++++++++++++++
 tb/tb_mmio_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - MMIO register window beside dmem on the processor data bus
//
// Purpose:
//   Decodes the processor's dmem address/data/write-enable signals and answers a
//   16-word register window at address_dmem[11:4] == BASE. Read data and the select
//   flag are registered, so they line up with the one-cycle dmem syncram latency.
//   Registers: 0x0 CYCLE (ro), 0x1 TXDATA (wo, byte FIFO push),
//              0x2 STATUS (write clears overflow), 0x3 SCRATCH (rw), others read 0.
//
// Optional build feature:
//   MMIO_CYCLE_COUNTER_EN - when defined, the 32-bit free-running CYCLE counter is
//   built. When undefined, no counter flops are built and CYCLE reads return 0.
//
// Ports:
//   clock        in   single clock, shared with dmem
//   reset        in   asynchronous active-low reset
//   address_dmem in   [11:0] word address from the processor
//   data         in   [31:0] store data from the processor
//   wren         in   store strobe
//   q_mmio       out  [31:0] registered read data (0 on a miss)
//   sel_mmio     out  registered flag: previous-cycle address hit the window
//   out_valid    out  transmit FIFO non-empty
//   out_data     out  [7:0] transmit FIFO head byte (0 when empty)
//   out_ready    in   consumer accepts the head byte

module mmio_responder #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] BASE       = 8'hFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_mmio,
  output logic        sel_mmio,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready
);

  localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] L_DEPTH = (AW + 1)'(FIFO_DEPTH);

  localparam logic [3:0] REG_CYCLE   = 4'h0;
  localparam logic [3:0] REG_TXDATA  = 4'h1;
  localparam logic [3:0] REG_STATUS  = 4'h2;
  localparam logic [3:0] REG_SCRATCH = 4'h3;

  // Decode
  logic        w_hit;
  logic [3:0]  w_reg;
  logic        w_tx_wr;
  logic        w_stat_wr;
  logic        w_scr_wr;

  // FIFO control
  logic        w_pop;
  logic        w_push;
  logic        w_full;
  logic        w_empty;
  logic        w_ovf_set;

  // Read path
  logic [31:0] w_cycle;
  logic [31:0] w_status;
  logic [31:0] w_rdata;

  // State
  logic [31:0]   r_scratch;
  logic          r_ovf;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_mem [FIFO_DEPTH];

  assign w_hit     = (address_dmem[11:4] == BASE);
  assign w_reg     = address_dmem[3:0];
  assign w_tx_wr   = w_hit && wren && (w_reg == REG_TXDATA);
  assign w_stat_wr = w_hit && wren && (w_reg == REG_STATUS);
  assign w_scr_wr  = w_hit && wren && (w_reg == REG_SCRATCH);

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == L_DEPTH);
  assign w_pop     = !w_empty && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push    = w_tx_wr && (!w_full || w_pop);
  assign w_ovf_set = w_tx_wr && !w_push;

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  assign w_cycle = r_cycle;
`else
  assign w_cycle = '0;
`endif

  // Status is sampled from pre-edge state, so a same-cycle push/pop is not reflected.
  assign w_status = {21'd0, 7'(r_count), 1'b0, r_ovf, w_full, w_empty};

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_CYCLE:   w_rdata = w_cycle;
      REG_STATUS:  w_rdata = w_status;
      REG_SCRATCH: w_rdata = r_scratch;
      default:     w_rdata = '0;
    endcase
  end

  // Registered read response, one cycle behind the address like dmem.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_mmio   <= '0;
      sel_mmio <= 1'b0;
    end else begin
      q_mmio   <= w_hit ? w_rdata : 32'd0;
      sel_mmio <= w_hit;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_scratch <= '0;
    end else if (w_scr_wr) begin
      r_scratch <= data;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_stat_wr) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data[7:0];
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - directed self-checking bench for mmio_responder

module tb_mmio_responder;

  localparam logic [11:0] A_MISS = 12'h010;
  localparam logic [11:0] A_CYC  = 12'hFF0;
  localparam logic [11:0] A_TX   = 12'hFF1;
  localparam logic [11:0] A_STAT = 12'hFF2;
  localparam logic [11:0] A_SCR  = 12'hFF3;

  logic        clock;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_mmio;
  logic        sel_mmio;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  int total;
  int bad;

  logic [31:0] rq;
  logic        rs;
  logic [7:0]  exp_b;

  mmio_responder #(
    .FIFO_DEPTH(8),
    .BASE      (8'hFF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address_dmem(address_dmem),
    .data        (data),
    .wren        (wren),
    .q_mmio      (q_mmio),
    .sel_mmio    (sel_mmio),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    address_dmem = a;
    data         = d;
    wren         = 1'b1;
    @(posedge clock);
    #1;
    wren         = 1'b0;
    address_dmem = A_MISS;
    data         = '0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] q, output logic s);
    address_dmem = a;
    wren         = 1'b0;
    @(posedge clock);
    #1;
    q            = q_mmio;
    s            = sel_mmio;
    address_dmem = A_MISS;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    address_dmem = A_MISS;
    data         = '0;
    wren         = 1'b0;
    out_ready    = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_q",     q_mmio,    32'd0);
    check("rst_sel",   {31'd0, sel_mmio},  32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data",  {24'd0, out_data},  32'd0);

    reset = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    rd(A_CYC, rq, rs);
`ifdef MMIO_CYCLE_COUNTER_EN
    check("cycle_10", rq, 32'd10);
`else
    check("cycle_off", rq, 32'd0);
`endif
    check("cycle_sel", {31'd0, rs}, 32'd1);
    rd(A_CYC, rq, rs);
`ifdef MMIO_CYCLE_COUNTER_EN
    check("cycle_11", rq, 32'd11);
`else
    check("cycle_off2", rq, 32'd0);
`endif

    rd(A_MISS, rq, rs);
    check("miss_q",   rq, 32'd0);
    check("miss_sel", {31'd0, rs}, 32'd0);

    wr(A_SCR, 32'hDEADBEEF);
    rd(A_SCR, rq, rs);
    check("scratch_rd", rq, 32'hDEADBEEF);
    wr(12'h003, 32'h00000055);
    rd(A_SCR, rq, rs);
    check("scratch_miss_wr", rq, 32'hDEADBEEF);
    rd(A_TX, rq, rs);
    check("txdata_rd", rq, 32'd0);
    check("txdata_sel", {31'd0, rs}, 32'd1);
    rd(12'hFF7, rq, rs);
    check("unused_rd", rq, 32'd0);
    rd(A_STAT, rq, rs);
    check("status_empty", rq, 32'h01);

    for (int i = 0; i < 8; i++) begin
      wr(A_TX, 32'h41 + i);
      if (i == 0) begin
        check("first_push_valid", {31'd0, out_valid}, 32'd1);
        check("first_push_data",  {24'd0, out_data},  32'h41);
      end
    end
    rd(A_STAT, rq, rs);
    check("status_full", rq, 32'h82);
    wr(A_TX, 32'h50);
    rd(A_STAT, rq, rs);
    check("status_ovf", rq, 32'h86);
    check("head_stable", {24'd0, out_data}, 32'h41);
    wr(A_STAT, 32'h0);
    rd(A_STAT, rq, rs);
    check("status_ovf_clr", rq, 32'h82);

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'h41 + 8'(i);
      check("drain_valid", {31'd0, out_valid}, 32'd1);
      check("drain_data",  {24'd0, out_data},  {24'd0, exp_b});
      @(posedge clock);
      #1;
    end
    check("drained_valid", {31'd0, out_valid}, 32'd0);
    check("drained_data",  {24'd0, out_data},  32'd0);
    out_ready = 1'b0;
    rd(A_STAT, rq, rs);
    check("status_drained", rq, 32'h01);

    for (int i = 0; i < 8; i++) begin
      wr(A_TX, 32'h61 + i);
    end
    out_ready = 1'b1;
    wr(A_TX, 32'h99);
    out_ready = 1'b0;
    rd(A_STAT, rq, rs);
    check("status_push_pop_full", rq, 32'h82);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_b = (i == 7) ? 8'h99 : 8'h62 + 8'(i);
      check("pp_data", {24'd0, out_data}, {24'd0, exp_b});
      @(posedge clock);
      #1;
    end
    check("pp_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    wr(A_TX, 32'h71);
    wr(A_TX, 32'h72);
    wr(A_TX, 32'h73);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_data",  {24'd0, out_data},  32'd0);
    check("async_rst_sel",   {31'd0, sel_mmio},  32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    rd(A_STAT, rq, rs);
    check("status_after_rst", rq, 32'h01);
    rd(A_SCR, rq, rs);
    check("scratch_after_rst", rq, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
